// File: rtl/vc_rr_scheduler.sv
// rtl/vc_rr_scheduler.sv - round-robin drain of eight VC FIFOs into one egress FIFO
//
// Purpose: pops one non-empty per-VC FIFO per cycle in round-robin order and
// forwards the returned word to the downstream FIFO two cycles later.
// Ports:
//   i_clk, i_reset      rising-edge clock, asynchronous active-high reset
//   i_enable            permission to issue new pops
//   i_empty_fifos[7:0]  empty flag per input FIFO
//   i_data_in           read data of FIFO i on [i*DATA_WIDTH +: DATA_WIDTH]
//   i_almost_full_out   downstream almost-full (backpressure)
//   o_pop[7:0]          one-hot pop strobe
//   o_grant[2:0]        index of FIFO popped
//   o_push_out          write strobe to downstream FIFO
//   o_data_out          word to downstream FIFO
//   o_idle_out          nothing pending, nothing in flight, state IDLE
module vc_rr_scheduler #(
    parameter int DATA_WIDTH = 10
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_enable,
    input  logic [7:0]              i_empty_fifos,
    input  logic [8*DATA_WIDTH-1:0] i_data_in,
    input  logic                    i_almost_full_out,
    output logic [7:0]              o_pop,
    output logic [2:0]              o_grant,
    output logic                    o_push_out,
    output logic [DATA_WIDTH-1:0]   o_data_out,
    output logic                    o_idle_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARB   = 2'd1,
        S_STALL = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [2:0]            r_last;
    logic [7:0]            r_pop;
    logic [2:0]            r_grant;
    logic                  r_rd_valid;
    logic [2:0]            r_rd_idx;
    logic                  r_push;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_idle;

    logic [7:0]            w_eligible;
    logic                  w_any_eligible;
    logic                  w_do_pop;
    logic [2:0]            w_pick;
    logic                  w_idle_next;

    // First eligible index searching upward from last+1, wrapping mod 8.
    function automatic logic [2:0] rr_pick(input logic [7:0] elig, input logic [2:0] last);
        logic [2:0] idx;
        logic [2:0] res;
        logic       found;
        res   = last;
        found = 1'b0;
        for (int off = 1; off <= 8; off++) begin
            idx = last + 3'(off);
            if (!found && elig[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // A FIFO popped this cycle may still show a stale non-empty flag, so it
    // sits out the next arbitration.
    assign w_eligible     = ~i_empty_fifos & ~r_pop;
    assign w_any_eligible = |w_eligible;
    assign w_pick         = rr_pick(w_eligible, r_last);

    // In every state a pop goes out exactly when enabled, not backpressured
    // and something is eligible; the FSM below only tracks which phase we are in.
    assign w_do_pop = i_enable & ~i_almost_full_out & w_any_eligible;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_do_pop) w_next_state = S_ARB;
            end
            S_ARB: begin
                if (!i_enable)              w_next_state = S_IDLE;
                else if (i_almost_full_out) w_next_state = S_STALL;
                else if (!w_any_eligible)   w_next_state = S_IDLE;
            end
            S_STALL: begin
                if (!i_enable)               w_next_state = S_IDLE;
                else if (!i_almost_full_out) w_next_state = S_ARB;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Idle only once both pipeline stages behind the pop are empty too.
    assign w_idle_next = (w_next_state == S_IDLE) & ~w_do_pop & ~(|r_pop) & ~r_rd_valid;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_last     <= 3'd7;
            r_pop      <= 8'd0;
            r_grant    <= 3'd0;
            r_rd_valid <= 1'b0;
            r_rd_idx   <= 3'd0;
            r_push     <= 1'b0;
            r_data_out <= '0;
            r_idle     <= 1'b1;
        end else begin
            r_state <= w_next_state;
            if (w_do_pop) begin
                r_pop   <= 8'd1 << w_pick;
                r_grant <= w_pick;
                r_last  <= w_pick;
            end else begin
                r_pop   <= 8'd0;
            end
            r_rd_valid <= |r_pop;
            r_rd_idx   <= r_grant;
            r_push     <= r_rd_valid;
            if (r_rd_valid) begin
                r_data_out <= i_data_in[int'(r_rd_idx)*DATA_WIDTH +: DATA_WIDTH];
            end
            r_idle <= w_idle_next;
        end
    end

    assign o_pop      = r_pop;
    assign o_grant    = r_grant;
    assign o_push_out = r_push;
    assign o_data_out = r_data_out;
    assign o_idle_out = r_idle;

endmodule

// File: tb/tb_vc_rr_scheduler.sv
// tb/tb_vc_rr_scheduler.sv - scoreboard bench for vc_rr_scheduler
module tb_vc_rr_scheduler;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [7:0]  empty_fifos;
    logic [79:0] data_in;
    logic        af;
    logic [7:0]  pop;
    logic [2:0]  grant;
    logic        push;
    logic [9:0]  data_out;
    logic        idle;

    vc_rr_scheduler #(.DATA_WIDTH(10)) dut (
        .i_clk             (clk),
        .i_reset           (rst),
        .i_enable          (enable),
        .i_empty_fifos     (empty_fifos),
        .i_data_in         (data_in),
        .i_almost_full_out (af),
        .o_pop             (pop),
        .o_grant           (grant),
        .o_push_out        (push),
        .o_data_out        (data_out),
        .o_idle_out        (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    logic [9:0] fq [8][$];
    int         exp_grant_q[$];
    logic [9:0] exp_data_q[$];
    int         pop_log[$];
    int         push_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops expectations as the DUT presents pops and pushes.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (pop != 8'd0) begin
                pop_log.push_back(cyc);
                if (exp_grant_q.size() == 0) begin
                    chk("unexpected_pop", {24'd0, pop}, 32'd0);
                end else begin
                    int g;
                    g = exp_grant_q.pop_front();
                    chk("pop_grant", {29'd0, grant}, g);
                    chk("pop_onehot", {24'd0, pop}, 32'd1 << g);
                end
            end
            if (push) begin
                push_log.push_back(cyc);
                if (exp_data_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_push actual=%0h required=none", data_out);
                end else begin
                    logic [9:0] d;
                    d = exp_data_q.pop_front();
                    chk("push_data", {22'd0, data_out}, {22'd0, d});
                end
            end
        end
    end

    task automatic refresh_empty();
        for (int i = 0; i < 8; i++) empty_fifos[i] = (fq[i].size() == 0);
    endtask

    // One cycle: wait for the falling edge, then let the FIFO models answer pops.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (pop[i]) begin
                if (fq[i].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_on_empty actual=fifo%0d required=nonempty", i);
                end else begin
                    data_in[i*10 +: 10] = fq[i].pop_front();
                end
            end
        end
        refresh_empty();
    endtask

    task automatic load(input int idx, input int n, input logic [9:0] base);
        for (int k = 1; k <= n; k++) fq[idx].push_back(base + 10'(k - 1));
        refresh_empty();
    endtask

    task automatic expect_pop(input int g, input logic [9:0] d);
        exp_grant_q.push_back(g);
        exp_data_q.push_back(d);
    endtask

    task automatic clear_all();
        for (int i = 0; i < 8; i++) fq[i].delete();
        exp_grant_q.delete();
        exp_data_q.delete();
        pop_log.delete();
        push_log.delete();
        refresh_empty();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        enable = 1'b0;
        af     = 1'b0;
        clear_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_grant_q.size() != 0 || exp_data_q.size() != 0 || !idle) && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_drain_in_budget"}, n < budget, 1);
        chk({name, "_idle_after"}, idle, 1);
    endtask

    initial begin
        rst         = 1'b1;
        enable      = 1'b0;
        af          = 1'b0;
        data_in     = '0;
        empty_fifos = 8'hff;
        @(negedge clk);
        @(negedge clk);

        // reset state
        chk("rst_pop", pop, 0);
        chk("rst_grant", grant, 0);
        chk("rst_push", push, 0);
        chk("rst_data", data_out, 0);
        chk("rst_idle", idle, 1);

        // async reset mid-stream, unchecked prelude stream
        load(0, 3, 10'h0a1);
        load(1, 3, 10'h0b1);
        rst    = 1'b0;
        enable = 1'b1;
        tick(); tick(); tick();
        chk("pre_reset_push", push, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_pop", pop, 0);
        chk("async_rst_push", push, 0);
        chk("async_rst_idle", idle, 1);
        chk("async_rst_data", data_out, 0);
        do_reset();
        mon_en = 1'b1;
        load(0, 1, 10'h0a7);
        expect_pop(0, 10'h0a7);
        enable = 1'b1;
        run_until_idle("reset_first_grant", 40);

        // FIFOs 0,3,5 with two words: consecutive round-robin pops
        do_reset();
        load(0, 2, 10'h001);
        load(3, 2, 10'h181);
        load(5, 2, 10'h281);
        expect_pop(0, 10'h001); expect_pop(3, 10'h181); expect_pop(5, 10'h281);
        expect_pop(0, 10'h002); expect_pop(3, 10'h182); expect_pop(5, 10'h282);
        enable = 1'b1;
        run_until_idle("rr3", 60);
        chk("rr3_pop_count", pop_log.size(), 6);
        chk("rr3_push_count", push_log.size(), 6);
        if (pop_log.size() == 6 && push_log.size() == 6) begin
            for (int j = 1; j < 6; j++) chk("rr3_pop_back_to_back", pop_log[j] - pop_log[0], j);
            for (int j = 0; j < 6; j++) chk("rr3_push_latency", push_log[j] - pop_log[j], 2);
        end

        // single FIFO drains at one pop every two cycles
        do_reset();
        load(6, 4, 10'h301);
        for (int k = 0; k < 4; k++) expect_pop(6, 10'h301 + 10'(k));
        enable = 1'b1;
        run_until_idle("single", 60);
        chk("single_push_count", push_log.size(), 4);
        if (pop_log.size() == 4) begin
            for (int j = 1; j < 4; j++) chk("single_pop_spacing", pop_log[j] - pop_log[j-1], 2);
        end

        // backpressure after grant 3
        do_reset();
        load(0, 2, 10'h011);
        load(3, 2, 10'h191);
        load(5, 2, 10'h291);
        expect_pop(0, 10'h011); expect_pop(3, 10'h191); expect_pop(5, 10'h291);
        expect_pop(0, 10'h012); expect_pop(3, 10'h192); expect_pop(5, 10'h292);
        enable = 1'b1;
        begin
            int n;
            n = 0;
            while (!pop[3] && n < 20) begin tick(); n++; end
            chk("bp_saw_grant3", n < 20, 1);
        end
        af = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("bp_no_pop", pop, 0);
        end
        chk("bp_pops_before_stall", pop_log.size(), 2);
        chk("bp_inflight_pushes", push_log.size(), 2);
        af = 1'b0;
        run_until_idle("bp", 60);

        // enable dropped while FIFOs 1 and 2 hold words
        do_reset();
        load(1, 3, 10'h0c1);
        load(2, 3, 10'h141);
        expect_pop(1, 10'h0c1); expect_pop(2, 10'h141);
        expect_pop(1, 10'h0c2); expect_pop(2, 10'h142);
        expect_pop(1, 10'h0c3); expect_pop(2, 10'h143);
        enable = 1'b1;
        begin
            int n;
            n = 0;
            while (!pop[2] && n < 20) begin tick(); n++; end
            chk("en_saw_grant2", n < 20, 1);
        end
        enable = 1'b0;
        tick();
        chk("en_e1_pop", pop, 0);
        chk("en_e1_push", push, 1);
        chk("en_e1_idle", idle, 0);
        tick();
        chk("en_e2_push", push, 1);
        chk("en_e2_idle", idle, 0);
        tick();
        chk("en_e3_push", push, 0);
        chk("en_e3_idle", idle, 1);
        for (int k = 0; k < 4; k++) tick();
        chk("en_no_new_pops", pop_log.size(), 2);
        chk("en_idle_hold", idle, 1);
        enable = 1'b1;
        run_until_idle("en_resume", 60);

        // all FIFOs empty: stays idle
        do_reset();
        enable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("empty_pop", pop, 0);
            chk("empty_idle", idle, 1);
        end
        chk("empty_no_push", push_log.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vc_rr_scheduler.md
# vc_rr_scheduler

Round-robin scheduler that drains the eight per-virtual-channel input FIFOs into the single downstream (egress) FIFO of the PCIE datapath. It enters operation after the top-level control FSM reaches its IDLE/ACTIVE phase. It issues one-hot pops to non-empty FIFOs and forwards the popped word with a push strobe. It honours the downstream almost-full flag as backpressure and reports its own idle status.

## Interface

- DATA_WIDTH, 10, width of each FIFO data word
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  permission to issue new pops; driven by the control FSM
- empty_fifos  in  8  empty flag of FIFO i on bit i
- data_in  in  8*DATA_WIDTH  read data of FIFO i on bits [i*DATA_WIDTH +: DATA_WIDTH]; valid the cycle after its pop
- almost_full_out  in  1  downstream FIFO almost-full; backpressure
- pop  out  8  one-hot pop strobe to FIFO i; at most one bit set
- grant  out  3  index of FIFO currently popped
- push_out  out  1  write strobe to downstream FIFO
- data_out  out  DATA_WIDTH  word to downstream FIFO, valid when push_out=1
- idle_out  out  1  high when no pop is pending or in flight and state is IDLE

## Operation

- States: IDLE, ARB, STALL. Reset state is IDLE.
- Eligible FIFO i means all of:
  - empty_fifos[i]=0
  - pop[i] was not asserted in the current cycle. A FIFO popped on one cycle is ineligible on the next, which guards against stale empty flags.
- Round-robin pointer `last` holds the last granted index (reset 7). The search starts at last+1 and wraps mod 8. The first eligible index wins.
- IDLE:
  - pop=0.
  - -> ARB when enable=1, almost_full_out=0 and any FIFO is eligible. The first pop is issued on that same edge.
- ARB:
  - Each edge with enable=1, almost_full_out=0 and an eligible FIFO: pop <= onehot(k), grant <= k, last <= k. Otherwise pop <= 0.
  - -> STALL when almost_full_out=1 and enable=1.
  - -> IDLE when enable=0, or when no FIFO is eligible.
- STALL:
  - pop=0.
  - -> ARB when almost_full_out=0 and enable=1. The pop is issued on the same edge.
  - -> IDLE when enable=0.
- Data path (two stages):
  - rd_valid <= |pop, and rd_idx <= grant.
  - Next edge: push_out <= rd_valid, data_out <= slice rd_idx of data_in.
  - data_out holds its last value when push_out=0.
- In-flight words always complete: almost_full_out and enable never cancel a pop already issued or its push. The downstream almost-full threshold must reserve at least 2 entries.
- idle_out <= 1 when the next state is IDLE, the next pop is 0 and rd_valid is 0. Otherwise 0.
- Simultaneous events:
  - almost_full_out=1 and enable=0 on the same edge: IDLE takes precedence.
  - Grant pointer does not advance on cycles with no pop.

## Timing

- Async reset; all outputs take these values immediately, without a clock edge:
  - pop=0, grant=0, push_out=0, data_out=0, idle_out=1
  - state=IDLE, last=7, rd_valid=0
- All outputs are registered.
- Pop-to-push latency: pop high in cycle N -> FIFO data valid in N+1 -> push_out high in cycle N+2.
- Peak throughput is one push per cycle when two or more FIFOs are non-empty.
- A single non-empty FIFO drains at one pop every 2 cycles.
- Backpressure reaction: almost_full_out sampled high at edge E means no pop after E. Up to 2 pushes can still occur after E.
- enable falling at edge E: no pop after E; idle_out=1 two edges after the last pop clears.

## Test plan

- Reset: assert reset mid-stream with no clock edge -> pop=0, push_out=0, idle_out=1 immediately; after release with FIFO 0 non-empty, first grant=0.
- FIFOs 0, 3, 5 each hold two words, enable=1 -> pop order 0,3,5,0,3,5 on consecutive cycles; each push_out 2 cycles after its pop carries the matching data_in word.
- Only FIFO 6 non-empty with 4 words -> pop[6] asserted every other cycle; 4 pushes total; then idle_out=1.
- almost_full_out raised after grant=3 in the order 0,3,5 -> no pops while high; 1-2 in-flight pushes complete; on release the next grant is 5.
- enable dropped while FIFOs 1 and 2 are non-empty -> no new pops; in-flight push completes; state IDLE with idle_out=1; re-enable resumes from last+1.
- All FIFOs empty, enable=1 -> state stays IDLE, pop=0, idle_out=1 indefinitely.
